// File: rtl/ram_dual_arb_if.sv
// Requester-side bundle for ram_dual_arb: one instance per master.
// The master drives the request fields and receives grant and read-return
// signals; the arbiter sits on the slave side.
interface ram_dual_arb_if #(
    parameter int DW = 8,
    parameter int AW = 3
);
    logic          req;     // request valid
    logic          wr;      // 1 = write, 0 = read
    logic [AW-1:0] addr;    // request address
    logic [DW-1:0] wdata;   // write data, ignored on reads
    logic          gnt;     // request accepted this cycle (combinational)
    logic          rvalid;  // read data valid, one-cycle pulse
    logic [DW-1:0] rdata;   // read data, meaningful while rvalid is high

    modport master (
        output req, wr, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, wr, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/ram_dual_arb.sv
// Two-master arbiter/sequencer for the ram_dual 8x8 dual-port RAM.
// The RAM write port and read port are arbitrated independently, each with
// its own round-robin priority pointer. A read that targets the same address
// as the winning write in the same cycle is withheld for one cycle so that it
// returns the freshly written data. RAM controls are registered from the
// grants; read data comes back two cycles after the grant, tagged to the
// master that issued the read.
module ram_dual_arb #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    ram_dual_arb_if.slave m0,
    ram_dual_arb_if.slave m1,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr_in,
    output logic [DW-1:0] ram_d,
    output logic          ram_rd,
    output logic [AW-1:0] ram_addr_out,
    input  logic [DW-1:0] ram_q
);

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_e;

    // Write-port arbitration signals
    logic          w_wc0;
    logic          w_wc1;
    logic          w_wgo;
    master_e       w_wsel;
    logic [AW-1:0] w_waddr;
    logic [DW-1:0] w_wdata;

    // Read-port arbitration signals
    logic          w_rc0;
    logic          w_rc1;
    logic          w_rreq;
    logic          w_rgo;
    master_e       w_rsel;
    logic [AW-1:0] w_raddr;
    logic          w_collide;

    // Per-master grants
    logic          w_gnt0;
    logic          w_gnt1;

    // Priority pointers and read-return pipeline
    master_e       r_wpri;
    master_e       r_rpri;
    master_e       r_rd_owner;
    logic          r_ram_we;
    logic [AW-1:0] r_ram_addr_in;
    logic [DW-1:0] r_ram_d;
    logic          r_ram_rd;
    logic [AW-1:0] r_ram_addr_out;
    logic          r_rvalid0;
    logic          r_rvalid1;

    // Write-port winner: sole candidate, or the priority holder on contention
    always_comb begin
        w_wc0   = m0.req & m0.wr;
        w_wc1   = m1.req & m1.wr;
        w_wgo   = w_wc0 | w_wc1;
        w_wsel  = M0;
        if (w_wc0 && w_wc1) begin
            w_wsel = r_wpri;
        end else if (w_wc1) begin
            w_wsel = M1;
        end
        w_waddr = (w_wsel == M1) ? m1.addr  : m0.addr;
        w_wdata = (w_wsel == M1) ? m1.wdata : m0.wdata;
    end

    // Read-port winner, then withheld if it hits the winning write's address
    always_comb begin
        w_rc0  = m0.req & ~m0.wr;
        w_rc1  = m1.req & ~m1.wr;
        w_rreq = w_rc0 | w_rc1;
        w_rsel = M0;
        if (w_rc0 && w_rc1) begin
            w_rsel = r_rpri;
        end else if (w_rc1) begin
            w_rsel = M1;
        end
        w_raddr   = (w_rsel == M1) ? m1.addr : m0.addr;
        w_collide = w_wgo & w_rreq & (w_waddr == w_raddr);
        w_rgo     = w_rreq & ~w_collide;
    end

    // Grants are forced low while reset is asserted, since they are combinational
    always_comb begin
        w_gnt0 = rst_n & ((w_wgo & (w_wsel == M0)) | (w_rgo & (w_rsel == M0)));
        w_gnt1 = rst_n & ((w_wgo & (w_wsel == M1)) | (w_rgo & (w_rsel == M1)));
    end

    // Round-robin pointers: each moves away from the master it just granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wpri <= M0;
            r_rpri <= M0;
        end else begin
            if (w_wgo) begin
                r_wpri <= (w_wsel == M0) ? M1 : M0;
            end
            if (w_rgo) begin
                r_rpri <= (w_rsel == M0) ? M1 : M0;
            end
        end
    end

    // RAM write port: one-cycle write strobe per write grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ram_we      <= 1'b0;
            r_ram_addr_in <= '0;
            r_ram_d       <= '0;
        end else begin
            r_ram_we <= w_wgo;
            if (w_wgo) begin
                r_ram_addr_in <= w_waddr;
                r_ram_d       <= w_wdata;
            end
        end
    end

    // RAM read port: one-cycle read strobe per read grant, with owner tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ram_rd       <= 1'b0;
            r_ram_addr_out <= '0;
            r_rd_owner     <= M0;
        end else begin
            r_ram_rd <= w_rgo;
            if (w_rgo) begin
                r_ram_addr_out <= w_raddr;
                r_rd_owner     <= w_rsel;
            end
        end
    end

    // Read return: pulse the owner's rvalid in the cycle ram_q is valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_rvalid0 <= r_ram_rd & (r_rd_owner == M0);
            r_rvalid1 <= r_ram_rd & (r_rd_owner == M1);
        end
    end

    assign m0.gnt       = w_gnt0;
    assign m1.gnt       = w_gnt1;
    assign m0.rvalid    = r_rvalid0;
    assign m1.rvalid    = r_rvalid1;
    // Both masters see ram_q directly; rvalid says whose data it is
    assign m0.rdata     = ram_q;
    assign m1.rdata     = ram_q;

    assign ram_we       = r_ram_we;
    assign ram_addr_in  = r_ram_addr_in;
    assign ram_d        = r_ram_d;
    assign ram_rd       = r_ram_rd;
    assign ram_addr_out = r_ram_addr_out;

endmodule
